// File: rtl/alu_pkg.sv
// Shared op-code constants and FSM state type for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle,
// WIDTH cycles after start, with a one-cycle done pulse on the final iteration.
module mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   prod
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               running;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc     <= '0;
        mcand   <= {{WIDTH{1'b0}}, a};
        mplier  <= b;
        cnt     <= CW'(WIDTH - 1);
        running <= 1'b1;
      end else if (running) begin
        if (mplier[0]) begin
          acc <= acc + mcand;
        end
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        // cnt==0 marks the last of the WIDTH iterations
        if (cnt == '0) begin
          running <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end
    end
  end

  assign prod = acc;

endmodule

// File: rtl/alu_seq_unit.sv
// Registered eight-operation ALU with valid/ready handshakes on both sides;
// single-cycle ops complete in one clock, MUL runs through mul_iter.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf
);

  if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_width_check
    $error("alu_seq_unit: WIDTH must be a power of two and >= 4");
  end

  state_e             state_q, state_d;
  logic               accept;
  logic               is_mul;
  logic               mul_done;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (op == OP_MUL);
  assign out_valid = (state_q == DONE);

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .prod  (prod)
  );

  assign sum = {1'b0, a} + {1'b0, b};

  always_comb begin
    alu_res   = '0;
    alu_carry = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_SLL: alu_res = a << b[SHW-1:0];
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_carry = sum[WIDTH];
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SRL: alu_res = a >> b[SHW-1:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = is_mul ? BUSY : DONE;
      BUSY: if (mul_done) state_d = DONE;
      DONE: begin
        // in_ready follows out_ready here, so a new op can overlap the drain
        if (accept)         state_d = is_mul ? BUSY : DONE;
        else if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result     <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
    end else if (accept && !is_mul) begin
      result     <= alu_res;
      flag_zero  <= (alu_res == '0);
      flag_carry <= alu_carry;
      flag_ovf   <= 1'b0;
    end else if (state_q == BUSY && mul_done) begin
      result     <= prod[WIDTH-1:0];
      flag_zero  <= (prod[WIDTH-1:0] == '0);
      flag_carry <= 1'b0;
      flag_ovf   <= |prod[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH=16).
module tb_alu_seq_unit;

  localparam logic [2:0] T_AND = 3'b000, T_SLL = 3'b001, T_OR  = 3'b010, T_XOR = 3'b011;
  localparam logic [2:0] T_ADD = 3'b100, T_SLT = 3'b101, T_SRL = 3'b110, T_MUL = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  op = '0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic        flag_zero, flag_carry, flag_ovf;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  alu_seq_unit #(.WIDTH(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op         (op),
    .a          (a),
    .b          (b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string nm, input logic [15:0] er, input logic ec, input logic ez,
                         input logic eo);
    chk({nm, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, ".result"}, {16'd0, result}, {16'd0, er});
    chk({nm, ".flags"}, {29'd0, flag_carry, flag_zero, flag_ovf}, {29'd0, ec, ez, eo});
  endtask

  // Single op from IDLE with out_ready=1; leaves the unit back in IDLE.
  task automatic do_op(input string nm, input logic [2:0] o, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] er, input logic ec,
                       input logic ez);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out(nm, er, ec, ez, 1'b0);
    @(posedge clk);
  endtask

  task automatic do_mul(input string nm, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic eo);
    int unsigned cycles;
    logic        busy_ok;
    @(negedge clk);
    in_valid = 1'b1; op = T_MUL; a = x; b = y; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    // junk offered while busy must be ignored
    op = T_AND; a = 16'h1234; b = 16'h0000;
    cycles  = 0;
    busy_ok = 1'b1;
    while (!out_valid && cycles < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk({nm, ".in_ready_low"}, {31'd0, busy_ok}, 32'd1);
    chk({nm, ".latency"}, cycles, 32'd17);
    chk_out(nm, er, 1'b0, (er == 16'h0000), eo);
    @(posedge clk);
  endtask

  function automatic logic [16:0] ref_alu(input logic [2:0] o, input logic [15:0] x,
                                          input logic [15:0] y);
    logic [16:0] s;
    case (o)
      T_AND: ref_alu = {1'b0, x & y};
      T_SLL: ref_alu = {1'b0, x << y[3:0]};
      T_OR:  ref_alu = {1'b0, x | y};
      T_XOR: ref_alu = {1'b0, x ^ y};
      T_ADD: begin s = {1'b0, x} + {1'b0, y}; ref_alu = s; end
      T_SLT: ref_alu = {16'd0, ($signed(x) < $signed(y))};
      T_SRL: ref_alu = {1'b0, x >> y[3:0]};
      default: ref_alu = '0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  s_op [8];
    logic [15:0] s_a  [8];
    logic [15:0] s_b  [8];
    logic [16:0] exp;
    logic        stay_low;

    tbl[0]  = '{T_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    tbl[1]  = '{T_SLT, 16'hFFFF, 16'h0001, 16'h0001, 1'b0, 1'b0};
    tbl[2]  = '{T_SRL, 16'h8000, 16'h0013, 16'h1000, 1'b0, 1'b0};
    tbl[3]  = '{T_SLL, 16'h0001, 16'h000F, 16'h8000, 1'b0, 1'b0};
    tbl[4]  = '{T_AND, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1'b0};
    tbl[5]  = '{T_OR,  16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0};
    tbl[6]  = '{T_XOR, 16'h00F0, 16'h0FF0, 16'h0F00, 1'b0, 1'b0};
    tbl[7]  = '{T_SLT, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b1};
    tbl[8]  = '{T_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};
    tbl[9]  = '{T_SRL, 16'h1234, 16'h0010, 16'h1234, 1'b0, 1'b0};
    tbl[10] = '{T_XOR, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
    tbl[11] = '{T_ADD, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b1};
    tbl[12] = '{T_SLT, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.result", {16'd0, result}, 32'd0);
    chk("reset.flags", {29'd0, flag_carry, flag_zero, flag_ovf}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].c,
            tbl[i].z);
    end

    do_mul("mul_12x34", 16'h0012, 16'h0034, 16'h03A8, 1'b0);
    do_mul("mul_ovf", 16'h0100, 16'h0100, 16'h0000, 1'b1);
    do_mul("mul_ffff", 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    do_mul("mul_3x5", 16'h0003, 16'h0005, 16'h000F, 1'b0);

    // Backpressure: XOR held for 5 cycles while an OR waits
    @(negedge clk);
    in_valid = 1'b1; op = T_XOR; a = 16'h00F0; b = 16'h0FF0; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    op = T_OR; a = 16'h00F0; b = 16'h0F00;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d.valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("hold%0d.result", i), {16'd0, result}, 32'h0F00);
      chk($sformatf("hold%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp.in_ready_follows", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk_out("bp.or", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk("bp.drained", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a MUL
    in_valid = 1'b1; op = T_MUL; a = 16'h0012; b = 16'h0034;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst.out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst.result", {16'd0, result}, 32'd0);
    chk("midrst.flags", {29'd0, flag_carry, flag_zero, flag_ovf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst.in_ready", {31'd0, in_ready}, 32'd1);
    do_op("midrst.and", T_AND, 16'hFF00, 16'h0FF0, 16'h0F00, 1'b0, 1'b0);
    stay_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stay_low = 1'b0;
    end
    chk("midrst.no_stale_mul", {31'd0, stay_low}, 32'd1);

    // Back-to-back stream of single-cycle ops
    s_op = '{T_AND, T_SLL, T_OR, T_XOR, T_ADD, T_SLT, T_SRL, T_ADD};
    s_a  = '{16'hF0F0, 16'h0003, 16'h1200, 16'hFFFF, 16'hC000, 16'h8001, 16'hF000, 16'h0101};
    s_b  = '{16'h3C3C, 16'h0004, 16'h0034, 16'h5A5A, 16'h4001, 16'h0000, 16'h0024, 16'hFEFF};
    @(negedge clk);
    out_ready = 1'b1;
    in_valid = 1'b1; op = s_op[0]; a = s_a[0]; b = s_b[0];
    for (int i = 0; i < 8; i++) begin
      exp = ref_alu(s_op[i], s_a[i], s_b[i]);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("stream%0d.valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d.result", i), {16'd0, result}, {16'd0, exp[15:0]});
      chk($sformatf("stream%0d.carry", i), {31'd0, flag_carry}, {31'd0, exp[16]});
      chk($sformatf("stream%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
      if (i < 7) begin
        op = s_op[i+1]; a = s_a[i+1]; b = s_b[i+1];
      end else begin
        in_valid = 1'b0;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("stream.drained", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Parametrised, registered successor to the 3-bit-select ALU result mux.
- Computes one of eight operations on two WIDTH-bit operands and registers the result plus flags.
- Uses a valid/ready handshake on both input and output. MUL is iterative and multi-cycle.
- Sits between operand/decode logic and the register-file writeback path.

Parameters:
- WIDTH, 16, operand/result width; power of two, >= 4 (elaboration-time check).
- SHW, $clog2(WIDTH), derived; shift-amount bits taken from b.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands and op are valid this cycle.
- in_ready  output  1  unit can accept an operation this cycle.
- op  input  3  operation select (encoding below).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; for shifts only b[SHW-1:0] is used.
- out_valid  output  1  result/flags valid; held until accepted.
- out_ready  input  1  consumer accepts the result this cycle.
- result  output  WIDTH  registered result.
- flag_zero  output  1  result == 0.
- flag_carry  output  1  carry out of ADD; 0 for all other ops.
- flag_ovf  output  1  MUL product exceeded WIDTH bits; 0 for all other ops.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Op encoding (fixed, same as the previous-generation mux select order):
  - 000 AND, 001 SLL, 010 OR, 011 XOR
  - 100 ADD, 101 SLT, 110 SRL, 111 MUL
- SLT: signed two's-complement compare; result = {0..0, a<b}.
- SLL/SRL: logical shifts; zero fill; shift amount = b[SHW-1:0].
- ADD: {flag_carry, result} = a + b, computed WIDTH+1 bits wide.
- MUL: result = low WIDTH bits of a*b (unsigned); flag_ovf = |high WIDTH bits.
- Acceptance: an operation is accepted when in_valid && in_ready at a rising edge; op, a and b are captured on that edge.
- FSM states: IDLE, BUSY (MUL only), DONE.
  - IDLE: in_ready=1.
    - Accept non-MUL -> DONE; result and flags registered on the same edge (latency 1).
    - Accept MUL -> BUSY; the iteration counter loads WIDTH-1.
  - BUSY: in_ready=0.
    - One shift-add iteration per cycle; after WIDTH iterations -> DONE.
    - out_valid rises WIDTH+1 cycles after the acceptance edge.
  - DONE: out_valid=1; result and flags stable.
    - out_ready=0: stay in DONE.
    - out_ready=1: in_ready = out_ready. A new accept on the same edge goes directly to DONE (non-MUL) or BUSY (MUL), so back-to-back single-cycle ops run at one per cycle.
    - out_ready=1 without a new accept: -> IDLE.
- Changes to in_valid/op/a/b while BUSY or DONE (not accepted) are ignored.
- flag_zero is computed from the final result for every op, including MUL.
- Reset (any state, including mid-MUL):
  - State -> IDLE; any in-flight MUL is aborted.
  - out_valid=0, result=0, all flags=0.
  - in_ready=1 in the first cycle after rst_n deasserts.

Decomposition:
- alu_pkg: op code constants (OP_AND..OP_MUL), FSM state typedef (IDLE/BUSY/DONE).
- Sub-module mul_iter: iterative shift-add multiplier.
  - Inputs: start, a, b.
  - Outputs: done, prod[2*WIDTH-1:0].
  - Owns the WIDTH-cycle counter.
  - alu_seq_unit instantiates it and forms flag_ovf from prod.

Test Plan:
- Reset, then ADD a=0xFFFF b=0x0001 with out_ready=1 -> one cycle later out_valid=1, result=0x0000, carry=1, zero=1, ovf=0.
- MUL a=0x0012 b=0x0034 -> in_ready=0 for 16 cycles; out_valid exactly 17 cycles after accept; result=0x03A8, ovf=0, zero=0.
- MUL a=0x0100 b=0x0100 -> result=0x0000, ovf=1, zero=1. SLT a=0xFFFF b=0x0001 -> result=0x0001. SRL a=0x8000 b=0x0013 -> shift 3, result=0x1000.
- Backpressure: XOR a=0x00F0 b=0x0FF0 (result 0x0F00) with out_ready=0 for 5 cycles -> out_valid and result held, in_ready=0; then out_ready=1 with OR queued -> accepted on the same edge, OR result next cycle.
- Reset mid-MUL: assert rst_n=0 at iteration 7 -> out_valid=0, result=0, flags=0 immediately; after release in_ready=1, and a fresh AND 0xFF00&0x0FF0 -> 0x0F00.
- Back-to-back stream of 8 single-cycle ops with out_ready=1 -> one result per cycle, in order, values matching a reference model.
